// File: rtl/arb_rr2_pkg.sv
// ---------------------------------------------------------------------------
// arb_pkg
// Shared types and constants for the two-requester round-robin arbiter.
//   arb_state_e       : arbiter FSM state encoding
//   ARB_NUM_REQ       : number of requesters (width of request/grant)
//   arb_grant_decode  : maps an FSM state to its one-hot-or-zero grant vector
// ---------------------------------------------------------------------------
package arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_GNT0 = 2'd1,
        ARB_GNT1 = 2'd2
    } arb_state_e;

    localparam int ARB_NUM_REQ = 2;

    // Grant vector implied by a state; only one bit can ever be set.
    function automatic logic [ARB_NUM_REQ-1:0] arb_grant_decode(input arb_state_e st);
        logic [ARB_NUM_REQ-1:0] g;
        case (st)
            ARB_GNT0: g = 2'b01;
            ARB_GNT1: g = 2'b10;
            default:  g = 2'b00;
        endcase
        return g;
    endfunction

endpackage

// File: rtl/arb_rr2_if.sv
// ---------------------------------------------------------------------------
// arb_if
// Request/grant bundle between requesters and the arbiter.
//   request : requester -> arbiter, level-sensitive want bits
//   grant   : arbiter -> requester, registered one-hot-or-zero
//   preempt : arbiter -> requester, one-cycle pulse on hold-limit revocation
// Modports: arb (arbiter side), req (requester side), mon (passive monitor).
// ---------------------------------------------------------------------------
interface arb_if;
    import arb_pkg::*;

    logic [ARB_NUM_REQ-1:0] request;
    logic [ARB_NUM_REQ-1:0] grant;
    logic                   preempt;

    modport arb (input request, output grant, output preempt);
    modport req (output request, input grant, input preempt);
    modport mon (input request, input grant, input preempt);

endinterface

// File: rtl/arb_rr2.sv
// ---------------------------------------------------------------------------
// arb_rr2
// Two-requester round-robin arbiter with bounded grant tenure.
// Ports:
//   clk   : single clock, all state updates on posedge
//   reset : synchronous, active-high
//   bus   : arb_if.arb (request in, grant/preempt out, both registered)
// Parameter:
//   MAX_HOLD : max consecutive granted cycles while the other requester
//              waits; 0 disables preemption.
// Every handover goes through ARB_IDLE, so grants never overlap.
// ---------------------------------------------------------------------------
module arb_rr2
    import arb_pkg::*;
#(
    parameter int MAX_HOLD = 16
) (
    input  logic clk,
    input  logic reset,
    arb_if.arb   bus
);

    // A zero-width counter is illegal, so MAX_HOLD=0 keeps a 1-bit register.
    localparam int HCW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
    localparam logic [HCW-1:0] HOLD_LIM = HCW'((MAX_HOLD > 0) ? (MAX_HOLD - 1) : 0);

    arb_state_e             state_q,       state_d;
    logic [HCW-1:0]         hold_cnt_q,    hold_cnt_d;
    logic                   last_winner_q, last_winner_d;
    logic [ARB_NUM_REQ-1:0] grant_q,       grant_d;
    logic                   preempt_q,     preempt_d;

    logic own_req_s;
    logic other_req_s;
    logic at_limit_s;

    // Request bits of the current holder and of the waiting requester.
    always_comb begin
        own_req_s   = 1'b0;
        other_req_s = 1'b0;
        case (state_q)
            ARB_GNT0: begin
                own_req_s   = bus.request[0];
                other_req_s = bus.request[1];
            end
            ARB_GNT1: begin
                own_req_s   = bus.request[1];
                other_req_s = bus.request[0];
            end
            default: begin
                own_req_s   = 1'b0;
                other_req_s = 1'b0;
            end
        endcase
    end

    assign at_limit_s = (MAX_HOLD != 0) && (hold_cnt_q == HOLD_LIM);

    // Next-state, tenure counter, tie-break memory and output decode.
    always_comb begin
        state_d       = state_q;
        hold_cnt_d    = hold_cnt_q;
        last_winner_d = last_winner_q;
        preempt_d     = 1'b0;
        case (state_q)
            ARB_IDLE: begin
                case (bus.request)
                    2'b01: begin
                        state_d       = ARB_GNT0;
                        hold_cnt_d    = '0;
                        last_winner_d = 1'b0;
                    end
                    2'b10: begin
                        state_d       = ARB_GNT1;
                        hold_cnt_d    = '0;
                        last_winner_d = 1'b1;
                    end
                    2'b11: begin
                        // Tie goes to whoever did not win last time.
                        if (last_winner_q) begin
                            state_d       = ARB_GNT0;
                            last_winner_d = 1'b0;
                        end else begin
                            state_d       = ARB_GNT1;
                            last_winner_d = 1'b1;
                        end
                        hold_cnt_d = '0;
                    end
                    default: begin
                        state_d = ARB_IDLE;
                    end
                endcase
            end
            ARB_GNT0, ARB_GNT1: begin
                if (!own_req_s) begin
                    state_d    = ARB_IDLE;
                    hold_cnt_d = '0;
                end else if (other_req_s) begin
                    if (at_limit_s) begin
                        state_d    = ARB_IDLE;
                        hold_cnt_d = '0;
                        preempt_d  = 1'b1;
                    end else if (MAX_HOLD != 0) begin
                        hold_cnt_d = hold_cnt_q + HCW'(1);
                    end else begin
                        // Preemption disabled: counter stays parked at zero.
                        hold_cnt_d = '0;
                    end
                end else begin
                    // Tenure only counts while the other side is contending.
                    hold_cnt_d = '0;
                end
            end
            default: begin
                state_d    = ARB_IDLE;
                hold_cnt_d = '0;
            end
        endcase
        grant_d = arb_grant_decode(state_d);
    end

    // State register and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ARB_IDLE;
            hold_cnt_q    <= '0;
            last_winner_q <= 1'b1;
            grant_q       <= 2'b00;
            preempt_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            hold_cnt_q    <= hold_cnt_d;
            last_winner_q <= last_winner_d;
            grant_q       <= grant_d;
            preempt_q     <= preempt_d;
        end
    end

    assign bus.grant   = grant_q;
    assign bus.preempt = preempt_q;

endmodule
